ser_shift_ctrl: RTL and testbench
=================================

SER_SHIFT_CTRL -- requirements
Module: ser_shift_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40: maximum WAIT-state cycles before the shift is abandoned.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_req, input, 1: shift request, sampled only when o_ready=1.
REQ-005 SHALL have port i_shamt, input, 5: shift amount 0..31.
REQ-006 SHALL have port i_right, input, 1: 1=right shift, 0=left shift.
REQ-007 SHALL have port i_arith, input, 1: 1=arithmetic right shift (ignored when i_right=0).
REQ-008 SHALL have port i_signbit, input, 1: operand bit 31, sampled with i_req.
REQ-009 SHALL have port i_sh_done, input, 1: shifter done flag from the serial shifter.
REQ-010 SHALL have port o_ready, output, 1: controller idle and accepting i_req.
REQ-011 SHALL have port o_sh_load, output, 1: load strobe to the shifter.
REQ-012 SHALL have port o_sh_shamt, output, 5: registered shift amount to the shifter.
REQ-013 SHALL have port o_sh_right, output, 1: registered direction to the shifter.
REQ-014 SHALL have port o_sh_signbit, output, 1: fill bit to the shifter.
REQ-015 SHALL have port o_rd_en, output, 1: result bit valid on the shifter output this cycle.
REQ-016 SHALL have port o_bit_idx, output, 5: index of the result bit currently streamed.
REQ-017 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-018 SHALL have port o_err, output, 1: one-cycle pulse coincident with o_done on timeout.

Function
REQ-019 SHALL implement states IDLE, LOAD, WAIT, STREAM, DONE; o_ready=1 only in IDLE.
REQ-020 IDLE: on i_req=1, SHALL capture i_shamt, i_right, i_arith and i_signbit into o_sh_shamt, o_sh_right and the fill-bit register, then go to LOAD.
REQ-021 SHALL drive o_sh_signbit = captured i_signbit AND captured i_arith AND captured i_right; otherwise 0.
REQ-022 LOAD: SHALL assert o_sh_load for exactly one cycle, then go to WAIT if captured shamt != 0, else go directly to STREAM.
REQ-023 WAIT: SHALL keep o_sh_load=1 and increment a timeout counter each cycle; on i_sh_done=1, SHALL go to STREAM next cycle.
REQ-024 WAIT: if the timeout counter reaches TIMEOUT-1 without i_sh_done, SHALL go to DONE with the error flag set.
REQ-025 If i_sh_done and the timeout occur in the same cycle, i_sh_done SHALL win (no error).
REQ-026 STREAM: SHALL assert o_rd_en for exactly 32 consecutive cycles, with o_bit_idx counting 0..31 (LSB first).
REQ-027 STREAM: after o_bit_idx=31, the counter SHALL wrap to 0 and the FSM SHALL go to DONE.
REQ-028 DONE: SHALL pulse o_done for one cycle (o_err=1 on timeout), then return to IDLE.
REQ-029 i_req asserted outside IDLE SHALL be ignored and have no effect.
REQ-030 Captured operands SHALL remain stable from LOAD through DONE regardless of input changes.
REQ-031 Latency, i_req to o_done: shamt=0 -> 35 cycles; otherwise 35 + (WAIT cycles up to and including i_sh_done).
REQ-032 o_rd_en, o_sh_load, o_done and o_err SHALL be mutually consistent with state: never two of o_sh_load, o_rd_en, o_done high together.

Reset
REQ-033 On i_rst=1 at a clock edge, SHALL enter IDLE from any state, including mid-STREAM and mid-WAIT.
REQ-034 On reset, SHALL clear all counters, o_sh_shamt, o_sh_right and the fill bit to 0, set o_ready=1 and all other outputs to 0.
REQ-035 A pending i_req in the reset cycle SHALL be dropped.

Verification
REQ-036 shamt=0, i_right=0, i_req one cycle -> LOAD 1 cycle, no WAIT, o_rd_en for 32 cycles with idx 0..31, o_done at cycle 35, o_err=0.
REQ-037 shamt=5, i_right=1, i_arith=1, i_signbit=1, i_sh_done high 4 cycles into WAIT -> o_sh_signbit=1 throughout, STREAM starts the next cycle, o_done once.
REQ-038 shamt=16, i_right=0, i_arith=1, i_signbit=1 -> o_sh_signbit=0 (left shift forces zero fill).
REQ-039 i_sh_done held 0, TIMEOUT=40 -> 40 WAIT cycles, no o_rd_en, o_done and o_err pulse together, then o_ready=1.
REQ-040 i_rst asserted at o_bit_idx=17 -> next cycle IDLE, o_rd_en=0, o_bit_idx=0, o_done never pulses.
REQ-041 i_req toggled during STREAM -> ignored; exactly one o_done per accepted request.

Source files
------------

// File: rtl/ser_shift_ctrl.sv
// ============================================================================
// Module   : ser_shift_ctrl
// Purpose  : Sequencer for a 32-bit serial shifter: load, wait, stream, done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_shift_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic [4:0] i_shamt,
    input  logic       i_right,
    input  logic       i_arith,
    input  logic       i_signbit,
    input  logic       i_sh_done,
    output logic       o_ready,
    output logic       o_sh_load,
    output logic [4:0] o_sh_shamt,
    output logic       o_sh_right,
    output logic       o_sh_signbit,
    output logic       o_rd_en,
    output logic [4:0] o_bit_idx,
    output logic       o_done,
    output logic       o_err
);

    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_tcnt;
    logic               r_ready;
    logic               r_load;
    logic               r_rd_en;
    logic               r_done;
    logic               r_err;
    logic [4:0]         r_shamt;
    logic               r_right;
    logic               r_fill;
    logic [4:0]         r_idx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_ready <= 1'b1;
            r_load  <= 1'b0;
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_shamt <= '0;
            r_right <= 1'b0;
            r_fill  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_shamt <= i_shamt;
                        r_right <= i_right;
                        // Zero fill unless this is an arithmetic right shift.
                        r_fill  <= i_signbit & i_arith & i_right;
                        r_ready <= 1'b0;
                        r_load  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tcnt <= '0;
                    if (r_shamt != 5'd0) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_load  <= 1'b0;
                        r_rd_en <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_STREAM;
                    end
                end
                S_WAIT: begin
                    // A done flag in the final timeout cycle still counts as success.
                    if (i_sh_done) begin
                        r_load  <= 1'b0;
                        r_rd_en <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_STREAM;
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_load  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (r_idx == 5'd31) begin
                        r_idx   <= '0;
                        r_rd_en <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_DONE: begin
                    r_tcnt  <= '0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_load  <= 1'b0;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_sh_load    = r_load;
    assign o_sh_shamt   = r_shamt;
    assign o_sh_right   = r_right;
    assign o_sh_signbit = r_fill;
    assign o_rd_en      = r_rd_en;
    assign o_bit_idx    = r_idx;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ser_shift_ctrl.sv
// ============================================================================
// Module   : tb_ser_shift_ctrl
// Purpose  : Randomised scoreboard bench for ser_shift_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_shift_ctrl;

    localparam int TO = 40;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_req = 1'b0;
    logic [4:0] i_shamt = '0;
    logic       i_right = 1'b0;
    logic       i_arith = 1'b0;
    logic       i_signbit = 1'b0;
    logic       i_sh_done = 1'b0;
    logic       o_ready, o_sh_load, o_sh_right, o_sh_signbit;
    logic       o_rd_en, o_done, o_err;
    logic [4:0] o_sh_shamt, o_bit_idx;

    ser_shift_ctrl #(.TIMEOUT(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_shamt     (i_shamt),
        .i_right     (i_right),
        .i_arith     (i_arith),
        .i_signbit   (i_signbit),
        .i_sh_done   (i_sh_done),
        .o_ready     (o_ready),
        .o_sh_load   (o_sh_load),
        .o_sh_shamt  (o_sh_shamt),
        .o_sh_right  (o_sh_right),
        .o_sh_signbit(o_sh_signbit),
        .o_rd_en     (o_rd_en),
        .o_bit_idx   (o_bit_idx),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0] shamt;
        bit         right;
        bit         fill;
        bit         err;
        int         lat;
        int         nrd;
        int         nld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: w = WAIT cycle in which the shifter reports done (0 = never).
    function automatic exp_t model(input logic [4:0] sh, input bit r, input bit a,
                                   input bit s, input int w);
        exp_t e;
        e.shamt = sh;
        e.right = r;
        e.fill  = s && a && r;
        e.err   = (sh != 0) && (w == 0 || w > TO);
        if (sh == 0) begin
            e.lat = 35; e.nrd = 32; e.nld = 1;
        end else if (e.err) begin
            e.lat = TO + 3; e.nrd = 0; e.nld = 1 + TO;
        end else begin
            e.lat = 35 + w; e.nrd = 32; e.nld = 1 + w;
        end
        return e;
    endfunction

    // Monitor
    int cyc = 0, acc = 0, rd_cnt = 0, ld_cnt = 0;
    bit in_txn = 0, idx_bad = 0, opnd_bad = 0, excl_bad = 0;
    always @(negedge i_clk) begin
        cyc++;
        if (i_rst) begin
            sb.delete();
            in_txn = 0;
        end else begin
            if (o_err && !o_done) chk("err_without_done", 1, 0);
            if (in_txn) begin
                if (int'(o_sh_load) + int'(o_rd_en) + int'(o_done) > 1) excl_bad = 1;
                if (o_ready) opnd_bad = 1;
                if (o_sh_load) ld_cnt++;
                if (o_rd_en) begin
                    if (int'(o_bit_idx) != rd_cnt) idx_bad = 1;
                    rd_cnt++;
                end
                if (sb.size() > 0 &&
                    (o_sh_shamt != sb[0].shamt || o_sh_right != sb[0].right ||
                     o_sh_signbit != sb[0].fill)) opnd_bad = 1;
            end
            if (o_done) begin
                if (!in_txn || sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc - acc + 1, e.lat);
                    chk("err_flag", int'(o_err), int'(e.err));
                    chk("rd_en_cycles", rd_cnt, e.nrd);
                    chk("load_cycles", ld_cnt, e.nld);
                    chk("bit_idx_seq_bad", int'(idx_bad), 0);
                    chk("operands_bad", int'(opnd_bad), 0);
                    chk("strobe_overlap", int'(excl_bad), 0);
                end
                in_txn = 0;
            end
            if (o_ready && i_req) begin
                in_txn = 1; acc = cyc; rd_cnt = 0; ld_cnt = 0;
                idx_bad = 0; opnd_bad = 0; excl_bad = 0;
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 1);
        chk({tag, "_rd_en"}, int'(o_rd_en), 0);
        chk({tag, "_bit_idx"}, int'(o_bit_idx), 0);
        chk({tag, "_load"}, int'(o_sh_load), 0);
        chk({tag, "_done_err"}, int'(o_done) + int'(o_err), 0);
        chk({tag, "_operands"}, int'(o_sh_shamt) + int'(o_sh_right) + int'(o_sh_signbit), 0);
    endtask

    // Runs one request from the #1-after-edge point with the controller idle.
    task automatic run_txn(input logic [4:0] sh, input bit r, input bit a, input bit s,
                           input int w, input bit toggle, input bit rst17);
        int  ld = 0;
        bit  fin = 0;
        exp_t e;
        i_shamt = sh; i_right = r; i_arith = a; i_signbit = s;
        i_sh_done = 0; i_req = 1;
        e = model(sh, r, a, s, w);
        sb.push_back(e);
        for (int n = 0; n < 200; n++) begin
            @(posedge i_clk); #1;
            ld = o_sh_load ? ld + 1 : 0;
            i_sh_done = (w != 0) && (ld == w + 1);
            if (o_ready) begin
                i_req = 0; i_sh_done = 0; fin = 1;
                break;
            end
            if (rst17 && o_rd_en && o_bit_idx == 5'd17) begin
                i_rst = 1; i_req = 1; i_sh_done = 0;
                @(posedge i_clk); #1;
                i_rst = 0; i_req = 0;
                reset_checks("midstream_rst");
                @(posedge i_clk); #1;
                chk("rst_req_dropped", int'(o_ready && !o_sh_load), 1);
                fin = 1;
                break;
            end
            if (toggle) begin
                i_req = 1'($urandom); i_shamt = 5'($urandom);
                i_right = 1'($urandom); i_arith = 1'($urandom); i_signbit = 1'($urandom);
            end else begin
                i_req = 0;
            end
        end
        if (!fin) chk("txn_no_return_to_ready", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_rst = 0;
        reset_checks("reset");
        @(posedge i_clk); #1;
        run_txn(5'd0,  0, 0, 0, 0,  0, 0);
        run_txn(5'd5,  1, 1, 1, 4,  0, 0);
        run_txn(5'd16, 0, 1, 1, 3,  0, 0);
        run_txn(5'd7,  1, 0, 1, 0,  0, 0);
        run_txn(5'd9,  1, 1, 1, TO, 0, 0);
        run_txn(5'd31, 1, 1, 0, TO + 1, 0, 0);
        run_txn(5'd0,  1, 1, 1, 0,  0, 1);
        run_txn(5'd3,  0, 0, 0, 2,  1, 0);
        run_txn(5'd0,  1, 1, 1, 0,  1, 0);
        for (int k = 0; k < 30; k++) begin
            logic [4:0] sh;
            int w;
            sh = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            w = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 3));
            run_txn(sh, 1'($urandom), 1'($urandom), 1'($urandom), w,
                    1'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        repeat (3) @(posedge i_clk);
        #1;
        chk("queue_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
